// File: rtl/clock_setter_pkg.sv
// rtl/clock_setter_pkg.sv - shared state, key index, field mask and BCD constants
package clock_setter_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EDIT_MIN = 2'd1,
    EDIT_SEC = 2'd2
  } state_t;

  localparam int K_MODE = 0;
  localparam int K_SEL  = 1;
  localparam int K_INC  = 2;
  localparam int K_DEC  = 3;

  localparam logic [3:0] SEL_MIN  = 4'b1100;
  localparam logic [3:0] SEL_SEC  = 4'b0011;
  localparam logic [3:0] SEL_NONE = 4'b0000;

  localparam logic [7:0] BCD_FIELD_MAX = 8'h59;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser, debounce counter and press event for one key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            level;
  logic            level_d;
  logic [DB_W-1:0] cnt;

  // Synchroniser resets to the released level so no false press follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= key;
      sync2   <= sync1;
      level_d <= level;
      press   <= level_d & ~level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_setter.sv
// rtl/clock_setter.sv - push-button MM:SS time-setting front end for the counter chain
module clock_setter
  import clock_setter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  KEY,
  input  logic [15:0] CUR_DIGITS,
  output logic [15:0] SET_DIGITS,
  output logic        LOAD,
  output logic        RUN_EN,
  output logic [3:0]  EDIT_SEL
);

  function automatic logic [7:0] bcd_sanitize(input logic [7:0] f);
    if (f[7:4] > BCD_FIELD_MAX[7:4] || f[3:0] > 4'd9) return 8'h00;
    return f;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] f);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = f[7:4];
    units = f[3:0];
    if (f == BCD_FIELD_MAX) return 8'h00;
    if (units == 4'd9) begin
      units = 4'd0;
      tens  = tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] f);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = f[7:4];
    units = f[3:0];
    if (f == 8'h00) return BCD_FIELD_MAX;
    if (units == 4'd0) begin
      units = 4'd9;
      tens  = tens - 4'd1;
    end else begin
      units = units - 4'd1;
    end
    return {tens, units};
  endfunction

  logic [3:0]  press;
  logic        ev_mode;
  logic        ev_sel;
  logic        ev_inc;
  logic        ev_dec;
  state_t      state;
  state_t      state_n;
  logic [15:0] set_q;
  logic [15:0] set_n;
  logic        load_q;
  logic        load_n;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
    ) u_db (
      .clk  (CLK),
      .rst  (RST),
      .key  (KEY[i]),
      .press(press[i])
    );
  end

  // Only the highest-priority event of a cycle survives.
  always_comb begin
    ev_mode = press[K_MODE];
    ev_sel  = press[K_SEL] & ~press[K_MODE];
    ev_inc  = press[K_INC] & ~press[K_MODE] & ~press[K_SEL];
    ev_dec  = press[K_DEC] & ~press[K_MODE] & ~press[K_SEL] & ~press[K_INC];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RUN;
      set_q  <= 16'h0000;
      load_q <= 1'b0;
    end else begin
      state  <= state_n;
      set_q  <= set_n;
      load_q <= load_n;
    end
  end

  always_comb begin
    state_n = state;
    set_n   = set_q;
    load_n  = 1'b0;
    case (state)
      RUN: begin
        if (ev_mode) begin
          set_n   = {bcd_sanitize(CUR_DIGITS[15:8]), bcd_sanitize(CUR_DIGITS[7:0])};
          state_n = EDIT_MIN;
        end
      end
      EDIT_MIN: begin
        if (ev_mode) begin
          state_n = RUN;
          load_n  = 1'b1;
        end else if (ev_sel) begin
          state_n = EDIT_SEC;
        end else if (ev_inc) begin
          set_n[15:8] = bcd_inc(set_q[15:8]);
        end else if (ev_dec) begin
          set_n[15:8] = bcd_dec(set_q[15:8]);
        end
      end
      EDIT_SEC: begin
        if (ev_mode) begin
          state_n = RUN;
          load_n  = 1'b1;
        end else if (ev_sel) begin
          state_n = EDIT_MIN;
        end else if (ev_inc) begin
          set_n[7:0] = bcd_inc(set_q[7:0]);
        end else if (ev_dec) begin
          set_n[7:0] = bcd_dec(set_q[7:0]);
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    SET_DIGITS = set_q;
    LOAD       = load_q;
    RUN_EN     = (state == RUN);
    case (state)
      EDIT_MIN: EDIT_SEL = SEL_MIN;
      EDIT_SEC: EDIT_SEL = SEL_SEC;
      default:  EDIT_SEL = SEL_NONE;
    endcase
  end

endmodule
